// File: rtl/palette_pixel_fifo_if.sv
// RGB888 pixel stream from the palette FIFO toward the HDMI output.
// The master drives out_valid/out_rgb and the slave answers with out_ready.
interface palette_pixel_fifo_if;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_rgb;

    modport master (
        output out_valid,
        output out_rgb,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_rgb,
        output out_ready
    );
endinterface

// File: rtl/palette_pixel_fifo.sv
// Palette lookup stage: per-layer colour RAM, opacity test, duplicate suppression, RGB888 pixel FIFO.
// Optional feature: define PALETTE_DROP_COUNT_EN to build the saturating dropped-pixel counter.
module palette_pixel_fifo #(
    parameter int NUM_LAYERS = 32,
    parameter int NUM_COLORS = 32,
    parameter int COORD_W    = 11,
    parameter int FIFO_DEPTH = 256,
    localparam int LW = $clog2(NUM_LAYERS),
    localparam int CW = $clog2(NUM_COLORS),
    localparam int DW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_pipe,
    input  logic               rst,
    input  logic               ctrl_we,
    input  logic [LW-1:0]      ctrl_layer,
    input  logic [CW-1:0]      ctrl_color,
    input  logic               ctrl_rgb_sel,
    input  logic [15:0]        ctrl_wdata,
    output logic [15:0]        ctrl_rdata,
    input  logic               pipe_valid,
    input  logic               pipe_sof,
    input  logic [LW-1:0]      pipe_layer,
    input  logic [CW-1:0]      pipe_color,
    input  logic [COORD_W-1:0] pipe_x,
    input  logic [COORD_W-1:0] pipe_y,
    palette_pixel_fifo_if.master pix,
    output logic [DW-1:0]      fifo_level,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic               ovf_sticky,
    input  logic               ovf_clr,
    output logic [15:0]        drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Palette storage: {G,B} and R words live in RAM, opaque flags are flops so they can be reset
    logic [15:0]           gb_mem [NUM_LAYERS][NUM_COLORS];
    logic [7:0]            r_mem  [NUM_LAYERS][NUM_COLORS];
    logic [NUM_COLORS-1:0] opaque_reg [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] layer_hit;

    logic [15:0]        ctrl_rdata_reg;

    logic               s1_valid_reg;
    logic               s1_sof_reg;
    logic               s1_opaque_reg;
    logic [COORD_W-1:0] s1_x_reg;
    logic [COORD_W-1:0] s1_y_reg;
    logic [23:0]        s1_rgb_reg;

    logic [COORD_W-1:0] prev_x_reg;
    logic [COORD_W-1:0] prev_y_reg;

    logic [23:0]        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW-1:0]      rd_ptr_inc;
    logic [DW-1:0]      level_reg;
    logic [DW-1:0]      level_next;
    logic [23:0]        out_rgb_reg;
    logic               ovf_sticky_reg;

    logic               dup;
    logic               push_req;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // ------------------------------------------------------------------
    // Palette write and controller readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pipe) begin
        if (ctrl_we) begin
            if (ctrl_rgb_sel) begin
                r_mem[ctrl_layer][ctrl_color] <= ctrl_wdata[7:0];
            end else begin
                gb_mem[ctrl_layer][ctrl_color] <= ctrl_wdata;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer_hit
            assign layer_hit[gi] = ctrl_we && ctrl_rgb_sel && (ctrl_layer == LW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                opaque_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (layer_hit[i]) begin
                    opaque_reg[i][ctrl_color] <= ctrl_wdata[8];
                end
            end
        end
    end

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            ctrl_rdata_reg <= '0;
        end else if (ctrl_rgb_sel) begin
            ctrl_rdata_reg <= {7'b0, opaque_reg[ctrl_layer][ctrl_color], r_mem[ctrl_layer][ctrl_color]};
        end else begin
            ctrl_rdata_reg <= gb_mem[ctrl_layer][ctrl_color];
        end
    end

    // ------------------------------------------------------------------
    // S1: register request and read palette (old data on same-cycle write)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            s1_valid_reg  <= 1'b0;
            s1_sof_reg    <= 1'b0;
            s1_opaque_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= pipe_valid;
            s1_sof_reg    <= pipe_valid && pipe_sof;
            s1_opaque_reg <= opaque_reg[pipe_layer][pipe_color];
        end
    end

    always_ff @(posedge clk_pipe) begin
        if (pipe_valid) begin
            s1_x_reg   <= pipe_x;
            s1_y_reg   <= pipe_y;
            s1_rgb_reg <= {r_mem[pipe_layer][pipe_color], gb_mem[pipe_layer][pipe_color]};
        end
    end

    // ------------------------------------------------------------------
    // S2: opacity / duplicate decision and FIFO push
    // ------------------------------------------------------------------
    // A start-of-frame pixel bypasses the compare so it survives even at the all-ones coordinate
    assign dup      = !s1_sof_reg && (s1_x_reg == prev_x_reg) && (s1_y_reg == prev_y_reg);
    assign push_req = s1_valid_reg && s1_opaque_reg && !dup;
    assign pop      = pix.out_valid && pix.out_ready;
    assign push_ok  = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    // Frame start wins over a push of the previous frame's last pixel on the same edge
    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            prev_x_reg <= '1;
            prev_y_reg <= '1;
        end else if (pipe_sof) begin
            prev_x_reg <= '1;
            prev_y_reg <= '1;
        end else if (push_req) begin
            prev_x_reg <= s1_x_reg;
            prev_y_reg <= s1_y_reg;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead pixel FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pipe) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= s1_rgb_reg;
        end
    end

    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_comb begin
        level_next = level_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + DW'(1);
            2'b01:   level_next = level_reg - DW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            level_reg <= level_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
        end
    end

    // Head register: loaded straight from the push when the pushed pixel becomes the head,
    // otherwise from the slot behind the one being popped; held when the FIFO drains
    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            out_rgb_reg <= '0;
        end else if (push_ok && (level_reg == '0 || (pop && level_reg == DW'(1)))) begin
            out_rgb_reg <= s1_rgb_reg;
        end else if (pop && level_reg > DW'(1)) begin
            out_rgb_reg <= fifo_mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            ovf_sticky_reg <= 1'b0;
        end else if (drop) begin
            ovf_sticky_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_reg <= 1'b0;
        end
    end

`ifdef PALETTE_DROP_COUNT_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk_pipe or negedge rst) begin
        if (!rst) begin
            drop_count_reg <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_count_reg <= 16'd1;
            end else if (drop_count_reg != 16'hFFFF) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_count_reg <= '0;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign drop_count = '0;
`endif

    assign ctrl_rdata    = ctrl_rdata_reg;
    assign pix.out_valid = (level_reg != '0);
    assign pix.out_rgb   = out_rgb_reg;
    assign fifo_level    = level_reg;
    assign fifo_empty    = (level_reg == '0);
    assign fifo_full     = (level_reg == DW'(FIFO_DEPTH));
    assign ovf_sticky    = ovf_sticky_reg;

endmodule
